// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the nop encoding used for bubbles, and the op-field position.
package if_stage_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam int          OP_FIELD_MSB = 31;
  localparam int          OP_FIELD_LSB = 26;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: reset > flush > stall > load.
// With neither stall nor load, a bubble is inserted so ID never
// re-executes the instruction it already consumed.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              load,
  input  logic [31:0]       load_instr,
  input  logic [ADDR_W-1:0] load_pc4,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              valid
);

  // IF/ID register update with flush/stall/load priority
  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (stall) begin
      instr    <= instr;
      pc_plus4 <= pc_plus4;
      valid    <= valid;
    end else if (load) begin
      instr    <= load_instr;
      pc_plus4 <= load_pc4;
      valid    <= 1'b1;
    end else begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the variable-latency imem
// request/ready handshake, applies ID-resolved branch/jump redirects and
// feeds the IF/ID register.
// Optional feature macro: IF_PERF_CNT_EN adds fetch/wait performance counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_d,
  input  logic              flush_d,
  input  logic              pcsrc_d,
  input  logic [ADDR_W-1:0] pcbranch_d,
  input  logic              jump_d,
  input  logic [ADDR_W-1:0] pcjump_d,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic [31:0]       instr_d,
  output logic [5:0]        op_d,
  output logic [ADDR_W-1:0] pc_plus4_d,
  output logic              valid_d,
  output logic              stall_f
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_wait_cnt
`endif
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] pend_target, pend_next;
  logic [31:0]       hold_word, hold_next;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic              redirect;
  logic              load;
  logic [31:0]       load_instr;

  assign pc_inc    = pc + ADDR_W'(4);
  assign redirect  = jump_d | pcsrc_d;
  assign target    = jump_d ? pcjump_d : pcbranch_d;
  assign imem_addr = pc;

  // State, PC, pending redirect target and stalled-word buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC[ADDR_W-1:0];
      pend_target <= '0;
      hold_word   <= NOP_INSTR;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      pend_target <= pend_next;
      hold_word   <= hold_next;
    end
  end

  // Next-state, PC update and handshake outputs
  always_comb begin
    state_next = state;
    pc_next    = pc;
    pend_next  = pend_target;
    hold_next  = hold_word;
    load       = 1'b0;
    load_instr = hold_word;
    imem_req   = 1'b0;
    stall_f    = 1'b0;
    unique case (state)
      IDLE: begin
        // Any stale response from before reset is ignored here.
        imem_req   = 1'b1;
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        stall_f  = ~imem_ready;
        if (redirect) begin
          if (imem_ready) begin
            pc_next = target;
          end else begin
            pend_next  = target;
            state_next = DISCARD;
          end
        end else if (imem_ready) begin
          if (!stall_d) begin
            load       = 1'b1;
            load_instr = imem_rdata;
            pc_next    = pc_inc;
          end else begin
            hold_next  = imem_rdata;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = target;
          state_next = FETCH;
        end else if (!stall_d) begin
          load       = 1'b1;
          load_instr = hold_word;
          pc_next    = pc_inc;
          state_next = FETCH;
        end
      end
      DISCARD: begin
        // Old address stays on the bus until its response is swallowed.
        imem_req = 1'b1;
        stall_f  = ~imem_ready;
        if (redirect) pend_next = target;
        if (imem_ready) begin
          pc_next    = redirect ? target : pend_target;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      stall_f  = 1'b0;
    end
  end

  if_id_reg #(.ADDR_W(ADDR_W)) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall_d),
    .flush      (flush_d),
    .load       (load),
    .load_instr (load_instr),
    .load_pc4   (pc_inc),
    .instr      (instr_d),
    .pc_plus4   (pc_plus4_d),
    .valid      (valid_d)
  );

  assign op_d = instr_d[OP_FIELD_MSB:OP_FIELD_LSB];

`ifdef IF_PERF_CNT_EN
  // Fetch counter tracks loads that actually land (flush overrides them);
  // wait counter tracks memory-stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (load && !flush_d) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_f)          perf_wait_cnt  <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule
